regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised 2-read/1-write integer register file for the core pipeline.
//   Adds posedge writes, write-to-read bypass, hardwired-zero register 0,
//   a sequenced post-reset clear and a per-register pending-write scoreboard.
//   Decode reads operands and busy flags here; writeback drives the write port.
// PARAMETERS
//   XLEN   32  data width of each register in bits
//   NREGS  32  number of architectural registers (power of two, >= 4)
//   AW     $clog2(NREGS)  address width (localparam, derived; not overridable)
// PORTS
//   clk        in   1     clock; all state updates on posedge
//   reset      in   1     synchronous, active-high reset
//   rd_addr_1  in   AW    read port 1 register index
//   rd_addr_2  in   AW    read port 2 register index
//   rd_data_1  out  XLEN  read port 1 data (combinational)
//   rd_data_2  out  XLEN  read port 2 data (combinational)
//   rd_busy_1  out  1     register at rd_addr_1 has an outstanding write
//   rd_busy_2  out  1     register at rd_addr_2 has an outstanding write
//   wr_enable  in   1     write strobe
//   wr_addr    in   AW    write index
//   wr_data    in   XLEN  write data
//   rsv_enable in   1     reserve: mark rsv_addr as pending producer
//   rsv_addr   in   AW    reserve index
//   ready      out  1     1 = clear sequence done, ports active
// BEHAVIOUR
//   States: CLEAR, RUN (2-bit or 1-bit encoding, implementer's choice).
//   Reset (sampled at posedge): state<=CLEAR, clr_idx<=1, pending<=0, ready<=0.
//   CLEAR: each cycle reg[clr_idx]<=0, clr_idx++; after writing index NREGS-1
//     state<=RUN, ready<=1. ready rises exactly NREGS-1 cycles after the
//     reset-released edge (31 for defaults). wr_enable/rsv_enable ignored.
//   CLEAR: rd_data_* = 0, rd_busy_* = 0 regardless of address.
//   reset asserted mid-CLEAR or mid-RUN: restart CLEAR from index 1.
//   RUN write: wr_enable && wr_addr!=0 -> reg[wr_addr]<=wr_data at posedge.
//   Register 0: reads always 0; writes and reservations to it ignored; never busy.
//   Bypass: wr_enable && wr_addr==rd_addr_n && rd_addr_n!=0 in RUN ->
//     rd_data_n = wr_data same cycle (zero-latency forward); else reg[rd_addr_n].
//   Scoreboard (RUN only), per register i!=0, updated at posedge:
//     set   pending[i] on rsv_enable && rsv_addr==i
//     clear pending[i] on wr_enable && wr_addr==i
//     both same cycle same index -> set wins (newer producer outstanding).
//   rd_busy_n = pending[rd_addr_n] && !(wr_enable && wr_addr==rd_addr_n);
//     a write being bypassed this cycle is not busy. Reserve affects busy
//     only from the next cycle.
//   Both read ports may address the same register; each sees identical data.
//   No output is registered besides ready; no X on outputs after first reset.
// TESTING
//   reset 1 cycle, then idle -> ready=0 for 31 cycles, 1 on 32nd; all reads 0.
//   RUN: write r5=0xDEADBEEF, read r5 same cycle -> rd_data=0xDEADBEEF (bypass);
//     next cycle with wr_enable=0 -> still 0xDEADBEEF.
//   write r0=0x1234, rsv r0 -> rd_data(r0)=0, rd_busy(r0)=0 forever.
//   rsv r7; next cycle rd_busy(r7)=1; write r7=0x55 -> busy=0 that cycle,
//     data=0x55; rsv r7 + write r7 same cycle -> busy=1 next cycle.
//   fill r1..r31 with index value, assert reset at clr_idx=10 -> ready stays 0
//     31 more cycles, all regs read 0 afterwards.
//   rsv/write during CLEAR -> no register change, pending all 0 after ready.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Two-read / one-write integer register file with write-to-read bypass,
// hardwired-zero r0, a sequenced post-reset clear and a pending-write scoreboard.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rd_addr_1,
    input  logic [AW-1:0]   rd_addr_2,
    output logic [XLEN-1:0] rd_data_1,
    output logic [XLEN-1:0] rd_data_2,
    output logic            rd_busy_1,
    output logic            rd_busy_2,
    input  logic            wr_enable,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            rsv_enable,
    input  logic [AW-1:0]   rsv_addr,
    output logic            ready
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [AW-1:0]     r_clr_idx;
    logic              r_ready;
    logic [XLEN-1:0]   r_regs [NREGS];
    logic [NREGS-1:0]  r_pending;

    logic              w_run;
    logic              w_last_clr;
    logic              w_wr_hit_1;
    logic              w_wr_hit_2;

    assign w_run      = (r_state == ST_RUN);
    assign w_last_clr = (r_clr_idx == AW'(NREGS - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: if (w_last_clr) w_state_next = ST_RUN;
            ST_RUN:   w_state_next = ST_RUN;
            default:  w_state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= AW'(1);
            r_ready   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + AW'(1);
            r_ready <= (w_state_next == ST_RUN);
        end
    end

    // Storage has no reset: the CLEAR walk zeroes it before any read can see it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                r_regs[r_clr_idx] <= '0;
            end else if (wr_enable && (wr_addr != '0)) begin
                r_regs[wr_addr] <= wr_data;
            end
        end
    end

    // Reservation is applied after the write clear so a same-cycle reserve wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else if (w_run) begin
            for (int i = 1; i < NREGS; i++) begin
                if (rsv_enable && (rsv_addr == AW'(i))) begin
                    r_pending[i] <= 1'b1;
                end else if (wr_enable && (wr_addr == AW'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    assign w_wr_hit_1 = wr_enable && (wr_addr == rd_addr_1);
    assign w_wr_hit_2 = wr_enable && (wr_addr == rd_addr_2);

    assign rd_data_1 = (!w_run || (rd_addr_1 == '0)) ? '0 :
                       w_wr_hit_1 ? wr_data : r_regs[rd_addr_1];
    assign rd_data_2 = (!w_run || (rd_addr_2 == '0)) ? '0 :
                       w_wr_hit_2 ? wr_data : r_regs[rd_addr_2];

    assign rd_busy_1 = w_run && (rd_addr_1 != '0) && r_pending[rd_addr_1] && !w_wr_hit_1;
    assign rd_busy_2 = w_run && (rd_addr_2 != '0) && r_pending[rd_addr_2] && !w_wr_hit_2;

    assign ready = r_ready;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, clear/reset sequences and
// random traffic checked against an array-based reference model.
module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic [AW-1:0]   rd_addr_1 = '0, rd_addr_2 = '0, wr_addr = '0, rsv_addr = '0;
  logic [XLEN-1:0] wr_data = '0;
  logic            wr_enable = 1'b0, rsv_enable = 1'b0;
  logic [XLEN-1:0] rd_data_1, rd_data_2;
  logic            rd_busy_1, rd_busy_2, ready;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_enable(rsv_enable), .rsv_addr(rsv_addr),
    .ready(ready)
  );

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_pend [NREGS];
  bit              m_ready;
  int              m_left;
  bit              m_valid = 0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (!m_ready || a == 0) return '0;
    if (wr_enable && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return m_ready && (a != 0) && m_pend[a] && !(wr_enable && wr_addr == a);
  endfunction

  // Applies the effect of one clock edge with the current inputs.
  task automatic model_step();
    if (reset) begin
      m_ready = 0;
      m_left  = NREGS - 1;
      for (int i = 0; i < NREGS; i++) m_pend[i] = 0;
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1;
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      end
    end else begin
      if (wr_enable && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_pend[wr_addr] = 0;
      end
      if (rsv_enable && rsv_addr != 0) m_pend[rsv_addr] = 1;
    end
    m_valid = 1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic we, input logic [AW-1:0] wa,
                       input logic [XLEN-1:0] wd, input logic rse, input logic [AW-1:0] ra,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input bit use_exp, input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                       input logic eb1, input logic eb2);
    @(negedge clk);
    reset = rst; wr_enable = we; wr_addr = wa; wr_data = wd;
    rsv_enable = rse; rsv_addr = ra; rd_addr_1 = a1; rd_addr_2 = a2;
    #1;
    if (m_valid) begin
      chk("model_rd_data_1", rd_data_1, exp_data(a1));
      chk("model_rd_data_2", rd_data_2, exp_data(a2));
      chk("model_rd_busy_1", {31'b0, rd_busy_1}, {31'b0, exp_busy(a1)});
      chk("model_rd_busy_2", {31'b0, rd_busy_2}, {31'b0, exp_busy(a2)});
      chk("model_ready", {31'b0, ready}, {31'b0, m_ready});
    end
    if (use_exp) begin
      chk("vec_rd_data_1", rd_data_1, e1);
      chk("vec_rd_data_2", rd_data_2, e2);
      chk("vec_rd_busy_1", {31'b0, rd_busy_1}, {31'b0, eb1});
      chk("vec_rd_busy_2", {31'b0, rd_busy_2}, {31'b0, eb2});
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    drive(0, 0, 0, 0, 0, 0, a1, a2, 0, 0, 0, 0, 0);
  endtask

  // Random write/reserve attempts while clearing; ready must still appear on the 32nd sample.
  task automatic check_clear_seq(input string tag);
    for (int k = 0; k < NREGS; k++) begin
      #1;
      chk(tag, {31'b0, ready}, {31'b0, (k == NREGS - 1)});
      if (k < NREGS - 1)
        drive(0, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, 1'($urandom_range(0, 1)),
              AW'($urandom), AW'($urandom), AW'($urandom), 1, 0, 0, 0, 0);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            rse;
    logic [AW-1:0]   ra;
    logic [AW-1:0]   a1, a2;
    logic [XLEN-1:0] e1, e2;
    logic            eb1, eb2;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    vecs[1]  = '{0, 0, 0,            0, 0, 5, 0, 32'hDEADBEEF, 0,            0, 0};
    vecs[2]  = '{1, 0, 32'h1234,     1, 0, 0, 0, 0,            0,            0, 0};
    vecs[3]  = '{0, 0, 0,            0, 0, 0, 0, 0,            0,            0, 0};
    vecs[4]  = '{0, 0, 0,            1, 7, 7, 5, 0,            32'hDEADBEEF, 0, 0};
    vecs[5]  = '{0, 0, 0,            0, 0, 7, 7, 0,            0,            1, 1};
    vecs[6]  = '{1, 7, 32'h55,       0, 0, 7, 7, 32'h55,       32'h55,       0, 0};
    vecs[7]  = '{0, 0, 0,            0, 0, 7, 7, 32'h55,       32'h55,       0, 0};
    vecs[8]  = '{1, 7, 32'h66,       1, 7, 7, 0, 32'h66,       0,            0, 0};
    vecs[9]  = '{0, 0, 0,            0, 0, 7, 7, 32'h66,       32'h66,       1, 1};
    vecs[10] = '{1, 7, 32'h77,       0, 0, 7, 7, 32'h77,       32'h77,       0, 0};
    vecs[11] = '{0, 0, 0,            0, 0, 7, 0, 32'h77,       0,            0, 0};

    // Startup: one reset cycle then the clear walk.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_clear_seq("startup_ready");

    for (int v = 0; v < 12; v++)
      drive(0, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].rse, vecs[v].ra,
            vecs[v].a1, vecs[v].a2, 1, vecs[v].e1, vecs[v].e2, vecs[v].eb1, vecs[v].eb2);

    // r0 stays zero and never busy afterwards.
    for (int k = 0; k < 3; k++) idle(0, 0);

    // Fill r1..r31 with their index and reserve a few, then reset twice (second at clr_idx 10).
    for (int i = 1; i < NREGS; i++)
      drive(0, 1, AW'(i), XLEN'(i), (i % 4 == 0), AW'(i + 1), AW'(i), 0, 1, XLEN'(i), 0, 0, 0);
    idle(9, 31);
    drive(1, 0, 0, 0, 0, 0, 9, 31, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++)
      drive(0, 1, AW'(k + 3), 32'hFFFF_0000, 1, AW'(k + 3), AW'(k + 3), AW'(k + 20), 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_clear_seq("midclear_ready");
    for (int i = 0; i < NREGS; i++)
      drive(0, 0, 0, 0, 0, 0, AW'(i), AW'(NREGS - 1 - i), 1, 0, 0, 0, 0);

    // Random traffic with rare resets.
    for (int n = 0; n < 600; n++)
      drive(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
            $urandom, 1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
